// File: rtl/ins_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ins_fetch_unit: assembles one 32-bit instruction from four byte reads.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ins_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       ins_out,
  output logic              ins_valid,
  output logic              busy,
  output logic              align_err,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [1:0]        idx;
  logic [7:0]        wait_cnt;
  logic [31:0]       buffer;
  logic [ADDR_W-1:2] base_hi;
  logic [1:0]        slot;
  logic [31:0]       merged;

  // Big-endian puts byte 0 in the top lane, so the lane index is 3-idx (= ~idx).
  assign slot = BIG_ENDIAN ? ~idx : idx;

  always_comb begin
    merged = buffer;
    case (slot)
      2'd0:    merged[7:0]   = mem_rdata;
      2'd1:    merged[15:8]  = mem_rdata;
      2'd2:    merged[23:16] = mem_rdata;
      default: merged[31:24] = mem_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      idx       <= 2'd0;
      wait_cnt  <= 8'd0;
      buffer    <= 32'h0;
      base_hi   <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      ins_out   <= 32'h0;
      ins_valid <= 1'b0;
      busy      <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      ins_valid <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req) begin
            if (pc[1:0] != 2'b00) begin
              align_err <= 1'b1;
            end else begin
              base_hi  <= pc[ADDR_W-1:2];
              mem_addr <= pc;
              idx      <= 2'd0;
              wait_cnt <= 8'd0;
              mem_rd   <= 1'b1;
              busy     <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            buffer   <= merged;
            wait_cnt <= 8'd0;
            if (idx == 2'd3) begin
              ins_out   <= merged;
              ins_valid <= 1'b1;
              mem_rd    <= 1'b0;
              state     <= DONE;
            end else begin
              idx      <= idx + 2'd1;
              mem_addr <= {base_hi, idx + 2'd1};
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort leaves ins_out untouched; the partial buffer is simply dropped.
            bus_err <= 1'b1;
            mem_rd  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_unit.sv
`default_nettype none
// Bench for ins_fetch_unit: big- and little-endian instances run in lockstep
// against one byte-memory model; a scoreboard holds the expected words.
module tb_ins_fetch_unit;

  typedef struct packed {
    logic [31:0] be;
    logic [31:0] le;
  } exp_t;

  logic        CLK, RST, fetch_req, mem_ack;
  logic [31:0] pc;
  logic [7:0]  mem_rdata;

  logic        be_rd, be_valid, be_busy, be_align, be_bus;
  logic [31:0] be_addr, be_out;
  logic        le_rd, le_valid, le_busy, le_align, le_bus;
  logic [31:0] le_addr, le_out;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_be = 32'h0;
  logic [31:0] last_le = 32'h0;

  logic [7:0]  mem_bytes [4];
  int          mem_lat   = 0;
  bit          never_ack = 1'b0;
  int          wcnt      = 0;

  ins_fetch_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(15)) dut_be (
    .CLK(CLK), .RST(RST), .fetch_req(fetch_req), .pc(pc),
    .mem_rd(be_rd), .mem_addr(be_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ins_out(be_out), .ins_valid(be_valid), .busy(be_busy),
    .align_err(be_align), .bus_err(be_bus)
  );

  ins_fetch_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(15)) dut_le (
    .CLK(CLK), .RST(RST), .fetch_req(fetch_req), .pc(pc),
    .mem_rd(le_rd), .mem_addr(le_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ins_out(le_out), .ins_valid(le_valid), .busy(le_busy),
    .align_err(le_align), .bus_err(le_bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Byte memory: acks after mem_lat idle cycles of an outstanding read.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge CLK);
      if (be_rd && !never_ack) begin
        if (wcnt == mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_bytes[be_addr[1:0]];
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every ins_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (be_valid !== le_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_lockstep: be=%b le=%b", be_valid, le_valid);
      end
      if ((be_valid | be_align | be_bus) === 1'b1) begin
        checks++;
        if ((int'(be_valid) + int'(be_align) + int'(be_bus)) > 1) begin
          errors++;
          $display("FAIL pulse_exclusive: valid=%b align=%b bus=%b", be_valid, be_align, be_bus);
        end
      end
      if (be_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got ins_out=%h with no fetch pending", be_out);
        end else begin
          e = sb.pop_front();
          if (be_out !== e.be || le_out !== e.le) begin
            errors++;
            $display("FAIL ins_out: got be=%h le=%h expected be=%h le=%h", be_out, le_out, e.be, e.le);
          end
        end
      end
    end
  end

  task automatic set_mem(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    mem_bytes[0] = b0;
    mem_bytes[1] = b1;
    mem_bytes[2] = b2;
    mem_bytes[3] = b3;
  endtask

  task automatic test_reset;
    RST = 1'b0; fetch_req = 1'b0; pc = 32'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({be_rd, be_valid, be_busy, be_align, be_bus} !== 5'b0 || be_addr !== 32'h0 || be_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got ctl=%b addr=%h out=%h expected all zero",
               {be_rd, be_valid, be_busy, be_align, be_bus}, be_addr, be_out);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_zero_wait;
    mem_lat = 0;
    set_mem(8'h8C, 8'h01, 8'h00, 8'h04);
    pc = 32'h100; fetch_req = 1'b1;
    sb.push_back('{be: 32'h8C010004, le: 32'h0400018C});
    @(negedge CLK);
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (be_rd !== 1'b1 || be_addr !== 32'h100 + i || be_valid !== 1'b0 || be_out !== last_be) begin
        errors++;
        $display("FAIL zw_read%0d: got rd=%b addr=%h valid=%b out=%h expected rd=1 addr=%h valid=0 out=%h",
                 i, be_rd, be_addr, be_valid, be_out, 32'h100 + i, last_be);
      end
      @(negedge CLK);
    end
    checks++;
    if (be_valid !== 1'b1 || be_busy !== 1'b1 || be_rd !== 1'b0) begin
      errors++;
      $display("FAIL zw_done: got valid=%b busy=%b rd=%b expected 1 1 0", be_valid, be_busy, be_rd);
    end
    last_be = 32'h8C010004; last_le = 32'h0400018C;
    @(negedge CLK);
    checks++;
    if (be_valid !== 1'b0 || be_busy !== 1'b0 || be_out !== last_be) begin
      errors++;
      $display("FAIL zw_idle: got valid=%b busy=%b out=%h expected 0 0 %h", be_valid, be_busy, be_out, last_be);
    end
  endtask

  task automatic test_reset_mid_fetch;
    mem_lat = 0;
    pc = 32'h200; fetch_req = 1'b1;
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (be_addr !== 32'h202 || be_rd !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got addr=%h rd=%b expected 00000202 1", be_addr, be_rd);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({be_rd, be_valid, be_busy, be_align, be_bus} !== 5'b0 || be_addr !== 32'h0 ||
        be_out !== 32'h0 || le_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got ctl=%b addr=%h be=%h le=%h expected all zero",
               {be_rd, be_valid, be_busy, be_align, be_bus}, be_addr, be_out, le_out);
    end
    last_be = 32'h0; last_le = 32'h0;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if (be_valid !== 1'b0 || be_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_after%0d: got valid=%b busy=%b expected 0 0", i, be_valid, be_busy);
      end
    end
  endtask

  task automatic test_wait_states;
    int n;
    mem_lat = 2;
    set_mem(8'h04, 8'h00, 8'h01, 8'h8C);
    pc = 32'h240; fetch_req = 1'b1;
    sb.push_back('{be: 32'h0400018C, le: 32'h8C010004});
    @(negedge CLK);
    fetch_req = 1'b0;
    n = 1;
    while (be_valid !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL ws_latency: got valid in cycle %0d expected 13", n);
    end
    last_be = 32'h0400018C; last_le = 32'h8C010004;
    @(negedge CLK);
    mem_lat = 0;
  endtask

  task automatic test_misaligned;
    pc = 32'h102; fetch_req = 1'b1;
    @(negedge CLK);
    fetch_req = 1'b0;
    checks++;
    if (be_align !== 1'b1 || be_rd !== 1'b0 || be_busy !== 1'b0 || be_out !== last_be || le_out !== last_le) begin
      errors++;
      $display("FAIL misaligned: got align=%b rd=%b busy=%b be=%h le=%h expected 1 0 0 %h %h",
               be_align, be_rd, be_busy, be_out, le_out, last_be, last_le);
    end
    @(negedge CLK);
    checks++;
    if (be_align !== 1'b0 || be_rd !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_after: got align=%b rd=%b expected 0 0", be_align, be_rd);
    end
  endtask

  task automatic test_timeout;
    never_ack = 1'b1;
    pc = 32'h300; fetch_req = 1'b1;
    @(negedge CLK);
    fetch_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (be_rd !== 1'b1 || be_addr !== 32'h300 || be_bus !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d: got rd=%b addr=%h bus=%b expected 1 00000300 0", k, be_rd, be_addr, be_bus);
      end
      @(negedge CLK);
    end
    checks++;
    if (be_bus !== 1'b1 || be_rd !== 1'b0 || be_busy !== 1'b0 || be_out !== last_be || le_out !== last_le) begin
      errors++;
      $display("FAIL to_abort: got bus=%b rd=%b busy=%b be=%h le=%h expected 1 0 0 %h %h",
               be_bus, be_rd, be_busy, be_out, le_out, last_be, last_le);
    end
    @(negedge CLK);
    checks++;
    if (be_bus !== 1'b0 || be_rd !== 1'b0) begin
      errors++;
      $display("FAIL to_after: got bus=%b rd=%b expected 0 0", be_bus, be_rd);
    end
    never_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    int idx, j;
    mem_lat = 0;
    set_mem(8'h12, 8'h34, 8'h56, 8'h78);
    pc = 32'h400; fetch_req = 1'b1;
    for (int f = 0; f < 3; f++) sb.push_back('{be: 32'h12345678, le: 32'h78563412});
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      idx = (k - 1) % 6;
      j   = (k - 1) / 6;
      checks++;
      if (idx <= 3) begin
        if (be_rd !== 1'b1 || be_addr !== 32'h400 + 32'h100 * j + idx) begin
          errors++;
          $display("FAIL b2b_addr_c%0d: got rd=%b addr=%h expected 1 %h",
                   k, be_rd, be_addr, 32'h400 + 32'h100 * j + idx);
        end
      end else if (idx == 4) begin
        if (be_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_valid_c%0d: got valid=%b expected 1", k, be_valid);
        end
      end else begin
        if (be_busy !== 1'b0 || be_rd !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_c%0d: got busy=%b rd=%b expected 0 0", k, be_busy, be_rd);
        end
      end
      if (k == 18) fetch_req = 1'b0;
      else pc = (k % 6 == 0) ? 32'h400 + 32'h100 * (k / 6) : 32'hF00 + 4 * k;
    end
    @(negedge CLK);
    checks++;
    if (be_busy !== 1'b0 || be_rd !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b rd=%b expected 0 0", be_busy, be_rd);
    end
    last_be = 32'h12345678; last_le = 32'h78563412;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_reset_mid_fetch();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
